// File: rtl/histogram_pkg.sv
// Shared constants and types for the histogram ROI detector.
// Optional feature macro: HISTOGRAM_PEAK_EN (per-axis peak bin index/count).
package histogram_pkg;

    localparam int X_BINS  = 240;
    localparam int Y_BINS  = 180;
    localparam int COUNT_W = 8;
    localparam int IDX_W   = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } roi_state_e;

    // A bin is occupied when its count reaches the threshold (threshold 0 => always).
    function automatic logic bin_occupied(input logic [COUNT_W-1:0] count,
                                          input logic [COUNT_W-1:0] threshold);
        return (count >= threshold);
    endfunction

endpackage

// File: rtl/histogram_axis_scanner.sv
// Single-axis histogram scanner: counts accepted beats, flags axis completion,
// and tracks first/last occupied bin (plus the largest bin under HISTOGRAM_PEAK_EN).
// Outputs are the next-state values so the owner can capture them on the same edge
// that accepts the final beat.
module histogram_axis_scanner
    import histogram_pkg::*;
#(
    parameter int NUM_BINS = X_BINS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               enable,
    input  logic               valid,
    input  logic [COUNT_W-1:0] count,
    input  logic [COUNT_W-1:0] threshold,
    output logic               done_next,
    output logic               found_next,
    output logic [IDX_W-1:0]   min_next,
    output logic [IDX_W-1:0]   max_next
`ifdef HISTOGRAM_PEAK_EN
    ,
    output logic [IDX_W-1:0]   peak_idx_next,
    output logic [COUNT_W-1:0] peak_count_next
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BINS - 1);

    logic [IDX_W-1:0] idx_r,   idx_b_s,   idx_n_s;
    logic             done_r,  done_b_s,  done_n_s;
    logic             found_r, found_b_s, found_n_s;
    logic [IDX_W-1:0] min_r,   min_b_s,   min_n_s;
    logic [IDX_W-1:0] max_r,   max_b_s,   max_n_s;
    logic             accept_s;
`ifdef HISTOGRAM_PEAK_EN
    logic [IDX_W-1:0]   peak_idx_r, peak_idx_b_s, peak_idx_n_s;
    logic [COUNT_W-1:0] peak_cnt_r, peak_cnt_b_s, peak_cnt_n_s;
`endif

    // Scan step: start from cleared state on frameStart, then fold in an accepted beat.
    always_comb begin
        idx_b_s   = clear ? '0   : idx_r;
        done_b_s  = clear ? 1'b0 : done_r;
        found_b_s = clear ? 1'b0 : found_r;
        min_b_s   = clear ? '0   : min_r;
        max_b_s   = clear ? '0   : max_r;
        idx_n_s   = idx_b_s;
        done_n_s  = done_b_s;
        found_n_s = found_b_s;
        min_n_s   = min_b_s;
        max_n_s   = max_b_s;
`ifdef HISTOGRAM_PEAK_EN
        peak_idx_b_s = clear ? '0 : peak_idx_r;
        peak_cnt_b_s = clear ? '0 : peak_cnt_r;
        peak_idx_n_s = peak_idx_b_s;
        peak_cnt_n_s = peak_cnt_b_s;
`endif
        // Beats past the last bin are dropped so the index never wraps.
        accept_s = enable && valid && !done_b_s;
        if (accept_s) begin
            idx_n_s  = idx_b_s + IDX_W'(1);
            done_n_s = (idx_b_s == LAST_IDX);
            if (bin_occupied(count, threshold)) begin
                if (!found_b_s) begin
                    min_n_s = idx_b_s;
                end else begin
                    min_n_s = min_b_s;
                end
                max_n_s   = idx_b_s;
                found_n_s = 1'b1;
            end else begin
                found_n_s = found_b_s;
            end
`ifdef HISTOGRAM_PEAK_EN
            // Strict compare: ties keep the earliest (lowest) index.
            if (count > peak_cnt_b_s) begin
                peak_idx_n_s = idx_b_s;
                peak_cnt_n_s = count;
            end else begin
                peak_cnt_n_s = peak_cnt_b_s;
            end
`endif
        end else begin
            idx_n_s = idx_b_s;
        end
    end

    // Scan state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_r   <= '0;
            done_r  <= 1'b0;
            found_r <= 1'b0;
            min_r   <= '0;
            max_r   <= '0;
`ifdef HISTOGRAM_PEAK_EN
            peak_idx_r <= '0;
            peak_cnt_r <= '0;
`endif
        end else begin
            idx_r   <= idx_n_s;
            done_r  <= done_n_s;
            found_r <= found_n_s;
            min_r   <= min_n_s;
            max_r   <= max_n_s;
`ifdef HISTOGRAM_PEAK_EN
            peak_idx_r <= peak_idx_n_s;
            peak_cnt_r <= peak_cnt_n_s;
`endif
        end
    end

    assign done_next  = done_n_s;
    assign found_next = found_n_s;
    assign min_next   = min_n_s;
    assign max_next   = max_n_s;
`ifdef HISTOGRAM_PEAK_EN
    assign peak_idx_next   = peak_idx_n_s;
    assign peak_count_next = peak_cnt_n_s;
`endif

endmodule

// File: rtl/histogram_roi_detector.sv
// Histogram ROI detector: scans X/Y bin-count streams per frame and publishes the
// bounding box of occupied bins once per frame with a one-cycle roiValid pulse.
// Optional feature macro: HISTOGRAM_PEAK_EN adds per-axis peak index/count outputs.
module histogram_roi_detector
    import histogram_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               frameStart,
    input  logic [COUNT_W-1:0] binThreshold,
    input  logic [COUNT_W-1:0] xHistogramIn,
    input  logic               xValid,
    input  logic [COUNT_W-1:0] yHistogramIn,
    input  logic               yValid,
    output logic [IDX_W-1:0]   xMin,
    output logic [IDX_W-1:0]   xMax,
    output logic [IDX_W-1:0]   yMin,
    output logic [IDX_W-1:0]   yMax,
    output logic               objectPresent,
    output logic               roiValid,
    output logic               busy
`ifdef HISTOGRAM_PEAK_EN
    ,
    output logic [IDX_W-1:0]   xPeakIdx,
    output logic [IDX_W-1:0]   yPeakIdx,
    output logic [COUNT_W-1:0] xPeakCount,
    output logic [COUNT_W-1:0] yPeakCount
`endif
);

    roi_state_e         state_r, state_n_s;
    logic [COUNT_W-1:0] thr_r;
    logic [COUNT_W-1:0] thr_s;
    logic               enable_s;
    logic               finish_s;
    logic               x_done_s, y_done_s, x_found_s, y_found_s;
    logic [IDX_W-1:0]   x_min_s, x_max_s, y_min_s, y_max_s;
`ifdef HISTOGRAM_PEAK_EN
    logic [IDX_W-1:0]   x_pk_idx_s, y_pk_idx_s;
    logic [COUNT_W-1:0] x_pk_cnt_s, y_pk_cnt_s;
`endif

    // The beat that coincides with frameStart must already use the new threshold.
    assign thr_s    = frameStart ? binThreshold : thr_r;
    assign enable_s = frameStart || (state_r == COLLECT);

    histogram_axis_scanner #(.NUM_BINS(X_BINS)) u_x_scan (
        .clk        (clk),
        .reset      (reset),
        .clear      (frameStart),
        .enable     (enable_s),
        .valid      (xValid),
        .count      (xHistogramIn),
        .threshold  (thr_s),
        .done_next  (x_done_s),
        .found_next (x_found_s),
        .min_next   (x_min_s),
        .max_next   (x_max_s)
`ifdef HISTOGRAM_PEAK_EN
        ,
        .peak_idx_next   (x_pk_idx_s),
        .peak_count_next (x_pk_cnt_s)
`endif
    );

    histogram_axis_scanner #(.NUM_BINS(Y_BINS)) u_y_scan (
        .clk        (clk),
        .reset      (reset),
        .clear      (frameStart),
        .enable     (enable_s),
        .valid      (yValid),
        .count      (yHistogramIn),
        .threshold  (thr_s),
        .done_next  (y_done_s),
        .found_next (y_found_s),
        .min_next   (y_min_s),
        .max_next   (y_max_s)
`ifdef HISTOGRAM_PEAK_EN
        ,
        .peak_idx_next   (y_pk_idx_s),
        .peak_count_next (y_pk_cnt_s)
`endif
    );

    // Frame sequencing: frameStart always restarts collection; completion of both axes ends it.
    always_comb begin
        state_n_s = state_r;
        finish_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (frameStart) begin
                    state_n_s = COLLECT;
                end else begin
                    state_n_s = IDLE;
                end
            end
            COLLECT: begin
                if (frameStart) begin
                    state_n_s = COLLECT;
                end else if (x_done_s && y_done_s) begin
                    state_n_s = DONE;
                    finish_s  = 1'b1;
                end else begin
                    state_n_s = COLLECT;
                end
            end
            DONE: begin
                if (frameStart) begin
                    state_n_s = COLLECT;
                end else begin
                    state_n_s = IDLE;
                end
            end
            default: begin
                state_n_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Threshold is captured only at frame start so mid-frame changes have no effect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            thr_r <= '0;
        end else if (frameStart) begin
            thr_r <= binThreshold;
        end else begin
            thr_r <= thr_r;
        end
    end

    // Result registers: loaded only on the edge that completes a frame, held otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xMin          <= '0;
            xMax          <= '0;
            yMin          <= '0;
            yMax          <= '0;
            objectPresent <= 1'b0;
            roiValid      <= 1'b0;
            busy          <= 1'b0;
`ifdef HISTOGRAM_PEAK_EN
            xPeakIdx      <= '0;
            yPeakIdx      <= '0;
            xPeakCount    <= '0;
            yPeakCount    <= '0;
`endif
        end else begin
            roiValid <= finish_s;
            busy     <= (state_n_s == COLLECT);
            if (finish_s) begin
                xMin          <= x_min_s;
                xMax          <= x_max_s;
                yMin          <= y_min_s;
                yMax          <= y_max_s;
                objectPresent <= x_found_s && y_found_s;
`ifdef HISTOGRAM_PEAK_EN
                xPeakIdx      <= x_pk_idx_s;
                yPeakIdx      <= y_pk_idx_s;
                xPeakCount    <= x_pk_cnt_s;
                yPeakCount    <= y_pk_cnt_s;
`endif
            end else begin
                objectPresent <= objectPresent;
            end
        end
    end

endmodule

// File: tb/tb_histogram_roi_detector.sv
// Scoreboard bench for histogram_roi_detector: expected ROI results are queued when
// a frame is driven and compared when roiValid pulses.
module tb_histogram_roi_detector;
    import histogram_pkg::*;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               frameStart = 1'b0;
    logic [COUNT_W-1:0] binThreshold = 8'd0;
    logic [COUNT_W-1:0] xHistogramIn = 8'd0;
    logic               xValid = 1'b0;
    logic [COUNT_W-1:0] yHistogramIn = 8'd0;
    logic               yValid = 1'b0;
    logic [IDX_W-1:0]   xMin, xMax, yMin, yMax;
    logic               objectPresent, roiValid, busy;
`ifdef HISTOGRAM_PEAK_EN
    logic [IDX_W-1:0]   xPeakIdx, yPeakIdx;
    logic [COUNT_W-1:0] xPeakCount, yPeakCount;
`endif

    histogram_roi_detector dut (
        .clk           (clk),
        .reset         (reset),
        .frameStart    (frameStart),
        .binThreshold  (binThreshold),
        .xHistogramIn  (xHistogramIn),
        .xValid        (xValid),
        .yHistogramIn  (yHistogramIn),
        .yValid        (yValid),
        .xMin          (xMin),
        .xMax          (xMax),
        .yMin          (yMin),
        .yMax          (yMax),
        .objectPresent (objectPresent),
        .roiValid      (roiValid),
        .busy          (busy)
`ifdef HISTOGRAM_PEAK_EN
        ,
        .xPeakIdx      (xPeakIdx),
        .yPeakIdx      (yPeakIdx),
        .xPeakCount    (xPeakCount),
        .yPeakCount    (yPeakCount)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int xmin; int xmax; int ymin; int ymax; int present;
        int xpi;  int xpc;  int ypi;  int ypc;
    } roi_t;

    roi_t        exp_q[$];
    roi_t        mon_e;
    int          n_total = 0;
    int          n_bad = 0;
    int          cycle_cnt = 0;
    int          last_beat_cyc = 0;
    logic [7:0]  xh[X_BINS];
    logic [7:0]  yh[Y_BINS];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Reference model of one frame's result from the bin tables.
    function automatic roi_t model(input logic [7:0] thr);
        roi_t r;
        bit xf = 1'b0, yf = 1'b0;
        r = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < X_BINS; i++) begin
            if (xh[i] >= thr) begin
                if (!xf) r.xmin = i;
                r.xmax = i; xf = 1'b1;
            end
            if (int'(xh[i]) > r.xpc) begin r.xpc = int'(xh[i]); r.xpi = i; end
        end
        for (int i = 0; i < Y_BINS; i++) begin
            if (yh[i] >= thr) begin
                if (!yf) r.ymin = i;
                r.ymax = i; yf = 1'b1;
            end
            if (int'(yh[i]) > r.ypc) begin r.ypc = int'(yh[i]); r.ypi = i; end
        end
        r.present = (xf && yf) ? 1 : 0;
        return r;
    endfunction

    task automatic fill_tables(input int x_lo, input int x_hi, input int y_lo, input int y_hi,
                               input logic [7:0] on_v, input logic [7:0] off_v);
        for (int i = 0; i < X_BINS; i++) xh[i] = (i >= x_lo && i <= x_hi) ? on_v : off_v;
        for (int i = 0; i < Y_BINS; i++) yh[i] = (i >= y_lo && i <= y_hi) ? on_v : off_v;
    endtask

    // Drive one frame; y_gaps skips every third cycle on Y; x_extra adds junk X beats after X completes.
    task automatic run_frame(input logic [7:0] thr, input bit y_gaps, input bit fs_beat,
                             input int x_lim, input int y_lim, input int x_extra, input bit push);
        int xi = 0, yi = 0, c = 0, xe = 0;
        if (push) exp_q.push_back(model(thr));
        @(posedge clk); #1;
        frameStart = 1'b1; binThreshold = thr; xValid = 1'b0; yValid = 1'b0;
        if (!fs_beat) begin
            @(posedge clk); #1;
            frameStart = 1'b0; binThreshold = 8'd0;
        end
        while (xi < x_lim || yi < y_lim) begin
            xValid = 1'b0; yValid = 1'b0; xHistogramIn = 8'hFF; yHistogramIn = 8'hFF;
            if (xi < x_lim) begin
                xValid = 1'b1; xHistogramIn = xh[xi]; xi++; last_beat_cyc = cycle_cnt;
            end else if (xe < x_extra) begin
                xValid = 1'b1; xe++;
            end
            if (yi < y_lim && (!y_gaps || (c % 3) != 2)) begin
                yValid = 1'b1; yHistogramIn = yh[yi]; yi++; last_beat_cyc = cycle_cnt;
            end
            @(posedge clk); #1;
            frameStart = 1'b0; binThreshold = 8'd0; c++;
        end
        xValid = 1'b0; yValid = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_xmin"}, xMin, 0);
        check_val({tag, "_xmax"}, xMax, 0);
        check_val({tag, "_ymin"}, yMin, 0);
        check_val({tag, "_ymax"}, yMax, 0);
        check_val({tag, "_present"}, objectPresent, 0);
        check_val({tag, "_roivalid"}, roiValid, 0);
        check_val({tag, "_busy"}, busy, 0);
    endtask

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Monitor: every roiValid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (roiValid) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_roi", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("xmin", xMin, mon_e.xmin);
                check_val("xmax", xMax, mon_e.xmax);
                check_val("ymin", yMin, mon_e.ymin);
                check_val("ymax", yMax, mon_e.ymax);
                check_val("present", objectPresent, mon_e.present);
                check_val("latency", cycle_cnt, last_beat_cyc + 1);
                check_val("busy_at_roi", busy, 0);
`ifdef HISTOGRAM_PEAK_EN
                check_val("xpeak_idx", xPeakIdx, mon_e.xpi);
                check_val("xpeak_cnt", xPeakCount, mon_e.xpc);
                check_val("ypeak_idx", yPeakIdx, mon_e.ypi);
                check_val("ypeak_cnt", yPeakCount, mon_e.ypc);
`endif
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset = 1'b1;

        // 1: box in the middle of both axes
        fill_tables(100, 119, 40, 59, 8'd10, 8'd0);
        run_frame(8'd5, 1'b0, 1'b0, X_BINS, Y_BINS, 0, 1'b1);

        // 2: everything empty
        fill_tables(1, 0, 1, 0, 8'd0, 8'd0);
        run_frame(8'd1, 1'b0, 1'b0, X_BINS, Y_BINS, 0, 1'b1);

        // 3: X finishes ~30 cycles before gapped Y; junk X beats after X completion
        fill_tables(100, 119, 40, 59, 8'd10, 8'd0);
        run_frame(8'd5, 1'b1, 1'b0, X_BINS, Y_BINS, 25, 1'b1);

        // 4: boundary bins, first beat coincides with frameStart
        fill_tables(1, 0, 1, 0, 8'd0, 8'd49);
        xh[0] = 8'd50; xh[X_BINS-1] = 8'd50; yh[Y_BINS-1] = 8'd50;
        run_frame(8'd50, 1'b0, 1'b1, X_BINS, Y_BINS, 0, 1'b1);

        // 5a: abandoned frame; previous ROI must hold, busy set
        repeat (2) @(posedge clk);
        run_frame(8'd5, 1'b0, 1'b0, 100, 0, 0, 1'b0);
        #1;
        check_val("hold_xmin", xMin, 0);
        check_val("hold_ymax", yMax, Y_BINS - 1);
        check_val("busy_collect", busy, 1);
        // 5b: restarted full frame
        fill_tables(10, 20, 170, 175, 8'd7, 8'd3);
        run_frame(8'd7, 1'b0, 1'b0, X_BINS, Y_BINS, 0, 1'b1);
        // 5c: extra beats while idle are ignored
        repeat (2) @(posedge clk);
        #1;
        xValid = 1'b1; yValid = 1'b1; xHistogramIn = 8'hFF; yHistogramIn = 8'hFF;
        repeat (10) @(posedge clk);
        #1;
        xValid = 1'b0; yValid = 1'b0;
        check_val("idle_xmin", xMin, 10);
        check_val("idle_ymax", yMax, 175);
        check_val("idle_busy", busy, 0);

        // threshold 0: every bin occupied; also peak ties (20 and 80 at 200)
        fill_tables(1, 0, 1, 0, 8'd0, 8'd9);
        xh[20] = 8'd200; xh[80] = 8'd200; yh[5] = 8'd30; yh[6] = 8'd30;
        run_frame(8'd0, 1'b0, 1'b0, X_BINS, Y_BINS, 0, 1'b1);

        // peak build: explicit case of tied maxima
        fill_tables(1, 0, 1, 0, 8'd0, 8'd0);
        xh[20] = 8'd200; xh[80] = 8'd200; yh[90] = 8'd60;
        run_frame(8'd50, 1'b0, 1'b0, X_BINS, Y_BINS, 0, 1'b1);

        // reset mid-frame: outputs return to 0, no roiValid for the partial frame
        repeat (3) @(posedge clk);
        run_frame(8'd5, 1'b0, 1'b0, 50, 50, 0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_outputs_zero("midreset");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        check_outputs_zero("after_reset");

        // drain: every queued expectation must have been consumed
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(posedge clk);
        check_val("drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
